// File: rtl/collision_pkg.sv
// Shared fp32 field positions, FSM state encoding and sample payload for the collision threshold stage.
package collision_pkg;

  localparam int unsigned FP_W        = 32;
  localparam int unsigned FP_SIGN     = 31;
  localparam int unsigned FP_EXP_MSB  = 30;
  localparam int unsigned FP_EXP_LSB  = 23;
  localparam int unsigned FP_MANT_W   = FP_EXP_LSB;
  localparam int unsigned FP_EXP_W    = FP_EXP_MSB - FP_EXP_LSB + 1;
  localparam logic [7:0]  FP_EXP_ALL1 = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  // One captured length/threshold pair
  typedef struct packed {
    logic [FP_W-1:0] len;
    logic [FP_W-1:0] thr;
  } sample_t;

  // NaN, or negative with non-zero magnitude (-0 is accepted as +0)
  function automatic logic fp32_invalid(input logic [FP_W-1:0] x);
    logic nan;
    logic neg;
    nan = (x[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_ALL1) && (x[FP_MANT_W-1:0] != '0);
    neg = x[FP_SIGN] && (x[FP_SIGN-1:0] != '0);
    return nan || neg;
  endfunction

endpackage

// File: rtl/fp32_le_cmp.sv
// Combinational a <= b for non-negative fp32; flags NaN / negative operands.
module fp32_le_cmp
  import collision_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        le,
  output logic        invalid
);

  logic mag_le;

  // Non-negative IEEE-754 values order like their unsigned magnitude bits
  always_comb begin
    mag_le  = (a[FP_SIGN-1:0] <= b[FP_SIGN-1:0]);
    invalid = fp32_invalid(a) || fp32_invalid(b);
    le      = mag_le && !invalid;
  end

endmodule

// File: rtl/collision_threshold_check.sv
// Captures a length sample on len_rdy rising, compares it against the threshold
// and presents a registered hit/miss verdict through a valid/ack handshake.
module collision_threshold_check
  import collision_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      len,
  input  logic             len_rdy,
  input  logic [31:0]      thresh,
  input  logic             out_ack,
  input  logic             clr,
  output logic             hit_valid,
  output logic             hit,
  output logic             nan_flag,
  output logic [31:0]      len_q,
  output logic [CNT_W-1:0] hit_count,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_nxt;
  sample_t          samp_q, samp_nxt;
  logic             len_rdy_prev;
  logic             hit_valid_nxt, hit_nxt, nan_nxt, overrun_nxt;
  logic [CNT_W-1:0] hit_count_nxt;
  logic             rise;
  logic             cmp_le, cmp_invalid;

  assign len_q = samp_q.len;
  assign rise  = len_rdy & ~len_rdy_prev;

  fp32_le_cmp u_cmp (
    .a       (samp_q.len),
    .b       (samp_q.thr),
    .le      (cmp_le),
    .invalid (cmp_invalid)
  );

  // State and verdict registers; prev resets high so a stale len_rdy is ignored
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= IDLE;
      samp_q       <= '0;
      len_rdy_prev <= 1'b1;
      hit_valid    <= 1'b0;
      hit          <= 1'b0;
      nan_flag     <= 1'b0;
      hit_count    <= '0;
      overrun      <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      samp_q       <= samp_nxt;
      len_rdy_prev <= len_rdy;
      hit_valid    <= hit_valid_nxt;
      hit          <= hit_nxt;
      nan_flag     <= nan_nxt;
      hit_count    <= hit_count_nxt;
      overrun      <= overrun_nxt;
    end
  end

  // Next-state, capture, handshake and status update
  always_comb begin
    state_nxt     = state_q;
    samp_nxt      = samp_q;
    hit_valid_nxt = hit_valid;
    hit_nxt       = hit;
    nan_nxt       = nan_flag;
    hit_count_nxt = hit_count;
    overrun_nxt   = overrun;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          samp_nxt.len = len;
          samp_nxt.thr = thresh;
          state_nxt    = COMPARE;
        end
      end
      COMPARE: begin
        hit_nxt       = cmp_le;
        nan_nxt       = cmp_invalid;
        hit_valid_nxt = 1'b1;
        state_nxt     = OUTPUT;
        if (cmp_le && (hit_count != CNT_MAX)) begin
          hit_count_nxt = hit_count + CNT_W'(1);
        end
        if (rise) begin
          overrun_nxt = 1'b1;
        end
      end
      OUTPUT: begin
        if (out_ack) begin
          hit_valid_nxt = 1'b0;
          if (rise) begin
            samp_nxt.len = len;
            samp_nxt.thr = thresh;
            state_nxt    = COMPARE;
          end else begin
            state_nxt = IDLE;
          end
        end else if (rise) begin
          overrun_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        hit_valid_nxt = 1'b0;
      end
    endcase

    // Clear takes priority over a same-cycle increment or overrun
    if (clr) begin
      hit_count_nxt = '0;
      overrun_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_collision_threshold_check.sv
// Directed bench for collision_threshold_check; a second instance with CNT_W=2 checks saturation.
module tb_collision_threshold_check;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] len;
  logic        len_rdy;
  logic [31:0] thresh;
  logic        out_ack;
  logic        clr;

  logic        hit_valid, hit, nan_flag, overrun;
  logic [31:0] len_q;
  logic [15:0] hit_count;

  logic        hit_valid2, hit2, nan_flag2, overrun2;
  logic [31:0] len_q2;
  logic [1:0]  hit_count2;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 CLK = ~CLK;

  collision_threshold_check #(.CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .len(len), .len_rdy(len_rdy), .thresh(thresh),
    .out_ack(out_ack), .clr(clr), .hit_valid(hit_valid), .hit(hit),
    .nan_flag(nan_flag), .len_q(len_q), .hit_count(hit_count), .overrun(overrun)
  );

  collision_threshold_check #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .len(len), .len_rdy(len_rdy), .thresh(thresh),
    .out_ack(out_ack), .clr(clr), .hit_valid(hit_valid2), .hit(hit2),
    .nan_flag(nan_flag2), .len_q(len_q2), .hit_count(hit_count2), .overrun(overrun2)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Raise len_rdy, wait for the verdict, then drop len_rdy (verdict stays pending)
  task automatic present(input logic [31:0] l, input logic [31:0] t);
    len = l; thresh = t; len_rdy = 1'b1;
    step();
    step();
    len_rdy = 1'b0;
  endtask

  task automatic ack();
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    step();
  endtask

  task automatic check_verdict(input string name, input logic e_hit, input logic e_nan,
                               input logic [31:0] e_len);
    checks++;
    if ({hit_valid, hit, nan_flag, len_q, hit_count} !== {1'b1, e_hit, e_nan, e_len, 16'(exp_cnt)}) begin
      errors++;
      $display("FAIL %s: got valid=%b hit=%b nan=%b len_q=%h cnt=%0d, want valid=1 hit=%b nan=%b len_q=%h cnt=%0d",
               name, hit_valid, hit, nan_flag, len_q, hit_count, e_hit, e_nan, e_len, exp_cnt);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({hit_valid, hit, nan_flag, len_q, hit_count, overrun} !== '0) begin
      errors++;
      $display("FAIL %s: got valid=%b hit=%b nan=%b len_q=%h cnt=%0d ovr=%b, want all zero",
               name, hit_valid, hit, nan_flag, len_q, hit_count, overrun);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; len_rdy = 1'b1; len = 32'h3F800000; thresh = 32'h40000000;
    out_ack = 1'b0; clr = 1'b0;
    step(); step();
    check_reset_vals("reset_values");
    RST = 1'b1;
    step(); step(); step();
    checks++;
    if (hit_valid !== 1'b0 || len_q !== 32'h0) begin
      errors++;
      $display("FAIL stale_rdy_after_reset: got valid=%b len_q=%h, want valid=0 len_q=0", hit_valid, len_q);
    end
    len_rdy = 1'b0;
    step();
  endtask

  task automatic test_compare();
    len = 32'h40000000; thresh = 32'h40400000; len_rdy = 1'b1;
    step();
    checks++;
    if (hit_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got valid=%b, want 0", hit_valid);
    end
    step();
    len_rdy = 1'b0;
    exp_cnt = 1;
    check_verdict("hit_2_le_3", 1'b1, 1'b0, 32'h40000000);
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    checks++;
    if (hit_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_clears_valid: got valid=%b, want 0", hit_valid);
    end
    step();

    present(32'h40400000, 32'h40000000);
    check_verdict("miss_3_gt_2", 1'b0, 1'b0, 32'h40400000);
    ack();
    present(32'h80000000, 32'h00000000);
    exp_cnt = 2;
    check_verdict("neg_zero_equal", 1'b1, 1'b0, 32'h80000000);
    ack();
    present(32'h7F800000, 32'h7F800000);
    exp_cnt = 3;
    check_verdict("inf_equal", 1'b1, 1'b0, 32'h7F800000);
    ack();
    present(32'h00000003, 32'h00000002);
    check_verdict("denorm_miss", 1'b0, 1'b0, 32'h00000003);
    ack();
  endtask

  task automatic test_invalid();
    present(32'h7FC00000, 32'h40000000);
    check_verdict("nan_len", 1'b0, 1'b1, 32'h7FC00000);
    ack();
    present(32'hBF800000, 32'h40000000);
    check_verdict("neg_len", 1'b0, 1'b1, 32'hBF800000);
    ack();
    present(32'h3F800000, 32'hFFC00000);
    check_verdict("nan_thresh", 1'b0, 1'b1, 32'h3F800000);
    ack();
  endtask

  task automatic test_overrun();
    present(32'h3F800000, 32'h40000000);
    exp_cnt++;
    step();
    len = 32'h41000000; len_rdy = 1'b1;
    step();
    len_rdy = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b, want 1", overrun);
    end
    check_verdict("overrun_verdict_kept", 1'b1, 1'b0, 32'h3F800000);
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_cnt = 0;
    checks++;
    if (overrun !== 1'b0 || hit_count !== 16'd0 || hit_valid !== 1'b1) begin
      errors++;
      $display("FAIL clr: got ovr=%b cnt=%0d valid=%b, want ovr=0 cnt=0 valid=1", overrun, hit_count, hit_valid);
    end
  endtask

  task automatic test_back_to_back();
    len = 32'h40000000; thresh = 32'h40400000; len_rdy = 1'b1; out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    checks++;
    if (hit_valid !== 1'b0 || overrun !== 1'b0 || len_q !== 32'h40000000) begin
      errors++;
      $display("FAIL ack_and_rise: got valid=%b ovr=%b len_q=%h, want valid=0 ovr=0 len_q=40000000",
               hit_valid, overrun, len_q);
    end
    step();
    len_rdy = 1'b0;
    exp_cnt = 1;
    check_verdict("ack_and_rise_verdict", 1'b1, 1'b0, 32'h40000000);
    ack();
  endtask

  task automatic test_reset_mid();
    len = 32'h3F800000; thresh = 32'h40000000; len_rdy = 1'b1;
    step();
    RST = 1'b0;
    step();
    check_reset_vals("reset_in_compare");
    RST = 1'b1;
    step(); step(); step();
    checks++;
    if (hit_valid !== 1'b0 || hit_count !== 16'd0) begin
      errors++;
      $display("FAIL no_recapture: got valid=%b cnt=%0d, want valid=0 cnt=0", hit_valid, hit_count);
    end
    len_rdy = 1'b0;
    step();
    exp_cnt = 0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      present(32'h3F800000, 32'h40000000);
      ack();
    end
    exp_cnt = 5;
    checks++;
    if (hit_count !== 16'd5 || hit_count2 !== 2'd3) begin
      errors++;
      $display("FAIL saturation: got cnt16=%0d cnt2=%0d, want 5 and 3", hit_count, hit_count2);
    end
    len = 32'h3F800000; thresh = 32'h40000000; len_rdy = 1'b1;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0; len_rdy = 1'b0;
    checks++;
    if (hit_count !== 16'd0 || hit_count2 !== 2'd0 || hit_valid !== 1'b1) begin
      errors++;
      $display("FAIL clr_over_incr: got cnt16=%0d cnt2=%0d valid=%b, want 0 0 1", hit_count, hit_count2, hit_valid);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_compare();
    test_invalid();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
